// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter shared types: FSM states, byte-enable codes,
// latency bounds and the byte-enable/address legality rule.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  localparam logic [3:0] BE_RD  = 4'b0000;
  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  function automatic logic be_legal(
    input logic [1:0] a,
    input logic [3:0] be
  );
    logic ok;
    ok = 1'b0;
    unique case (be)
      BE_RD:   ok = 1'b1;
      BE_B0:   ok = (a == 2'b00);
      BE_B1:   ok = (a == 2'b01);
      BE_B2:   ok = (a == 2'b10);
      BE_B3:   ok = (a == 2'b11);
      BE_HLO:  ok = (a[1] == 1'b0);
      BE_HHI:  ok = (a[1] == 1'b1);
      BE_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter bus bundle: two requesters, shared
// read-return bus and the single data-memory port.
interface dm_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata;
  logic        err0;
  logic        err1;
  logic        m_en;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_rdata;
  logic        busy;

  modport slave (
    input  req0, req1, addr0, addr1,
    input  wdata0, wdata1, be0, be1,
    input  m_rdata,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata, err0, err1,
    output m_en, m_addr, m_wdata, m_byteen,
    output busy
  );

  modport master (
    output req0, req1, addr0, addr1,
    output wdata0, wdata1, be0, be1,
    output m_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata, err0, err1,
    input  m_en, m_addr, m_wdata, m_byteen,
    input  busy
  );
endinterface

// File: rtl/dm_arbiter_rr.sv
// dm_arbiter winner select, one-hot {port1,port0}.
// DM_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module dm_arb_rr (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] win
);

`ifdef DM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      req0:            win = 2'b01;
      (!req0 && req1): win = 2'b10;
      default:         win = 2'b00;
    endcase
  end
`else
  // last==1 means port 1 was granted last
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req0 && req1):  win = last ? 2'b01 : 2'b10;
      (req0 && !req1): win = 2'b01;
      (!req0 && req1): win = 2'b10;
      default:         win = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU/DMA data-memory arbiter, one txn in flight.
// DM_ARB_FIXED_PRIO_EN selects fixed priority in dm_arb_rr.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  rr_win;
  logic        sel_req;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        legal;

  dm_arb_rr u_rr (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last_q),
    .win  (rr_win)
  );

  assign sel_req   = win_q ? bus.req1   : bus.req0;
  assign sel_addr  = win_q ? bus.addr1  : bus.addr0;
  assign sel_wdata = win_q ? bus.wdata1 : bus.wdata0;
  assign sel_be    = win_q ? bus.be1    : bus.be0;
  assign legal     = be_legal(sel_addr[1:0], sel_be);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.err0     = 1'b0;
    bus.err1     = 1'b0;
    bus.rvalid0  = 1'b0;
    bus.rvalid1  = 1'b0;
    bus.rdata    = 32'd0;
    bus.m_en     = 1'b0;
    bus.m_addr   = 32'd0;
    bus.m_wdata  = 32'd0;
    bus.m_byteen = 4'd0;
    bus.busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|rr_win) begin
          win_d   = rr_win[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.busy = 1'b1;
        state_d  = IDLE;
        // a dropped request aborts silently
        if (sel_req) begin
          last_d   = win_q;
          bus.gnt0 = !win_q;
          bus.gnt1 = win_q;
          if (legal) begin
            bus.m_en     = 1'b1;
            bus.m_addr   = sel_addr;
            bus.m_wdata  = sel_wdata;
            bus.m_byteen = sel_be;
            if (sel_be == BE_RD) begin
              state_d = WAIT;
              cnt_d   = LAT_M1;
            end
          end else begin
            bus.err0 = !win_q;
            bus.err1 = win_q;
          end
        end
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (cnt_q == 2'd0) begin
          bus.rvalid0 = !win_q;
          bus.rvalid1 = win_q;
          bus.rdata   = bus.m_rdata;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: MEM_LAT=1 and MEM_LAT=3 instances on shared
// stimulus, checked per cycle against a timeline model.
module tb_dm_arbiter;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        err0;
    logic        err1;
    logic        rvalid0;
    logic        rvalid1;
    logic        m_en;
    logic        busy;
    logic [3:0]  m_byteen;
    logic [31:0] rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
  } obs_t;

  logic clk;
  logic reset;
  int   n_pass = 0;
  int   n_tot = 0;

  dm_arbiter_if b1 ();
  dm_arbiter_if b3 ();

  assign b3.req0    = b1.req0;
  assign b3.req1    = b1.req1;
  assign b3.addr0   = b1.addr0;
  assign b3.addr1   = b1.addr1;
  assign b3.wdata0  = b1.wdata0;
  assign b3.wdata1  = b1.wdata1;
  assign b3.be0     = b1.be0;
  assign b3.be1     = b1.be1;
  assign b3.m_rdata = b1.m_rdata;

  dm_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  dm_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic bit legal(
    input logic [1:0] a,
    input logic [3:0] be
  );
    case (be)
      4'h0: return 1'b1;
      4'h1, 4'h2, 4'h4, 4'h8:
        return be == (4'h1 << a);
      4'h3: return a[1] == 1'b0;
      4'hC: return a[1] == 1'b1;
      4'hF: return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  int issue_at[2];
  int rv_at[2];
  int lat[2];
  bit win[2];
  bit last[2];
  int n = 0;

  task automatic model_step();
    obs_t a[2];
    obs_t e;
    bit r, w;
    logic [31:0] ad, wd;
    logic [3:0] be;
    a[0] = {b1.gnt0, b1.gnt1, b1.err0, b1.err1,
            b1.rvalid0, b1.rvalid1, b1.m_en, b1.busy,
            b1.m_byteen, b1.rdata, b1.m_addr, b1.m_wdata};
    a[1] = {b3.gnt0, b3.gnt1, b3.err0, b3.err1,
            b3.rvalid0, b3.rvalid1, b3.m_en, b3.busy,
            b3.m_byteen, b3.rdata, b3.m_addr, b3.m_wdata};
    for (int k = 0; k < 2; k++) begin
      e = '0;
      if (!reset) begin
        issue_at[k] = -1;
        rv_at[k]    = -1;
        last[k]     = 1'b1;
      end else if (n == issue_at[k]) begin
        w  = win[k];
        r  = w ? b1.req1 : b1.req0;
        ad = w ? b1.addr1 : b1.addr0;
        wd = w ? b1.wdata1 : b1.wdata0;
        be = w ? b1.be1 : b1.be0;
        e.busy = 1'b1;
        if (r) begin
          last[k] = w;
          e.gnt0  = !w;
          e.gnt1  = w;
          if (legal(ad[1:0], be)) begin
            e.m_en     = 1'b1;
            e.m_addr   = ad;
            e.m_wdata  = wd;
            e.m_byteen = be;
            if (be == 4'h0) rv_at[k] = n + lat[k];
          end else begin
            e.err0 = !w;
            e.err1 = w;
          end
        end
      end else if (n > issue_at[k] && n <= rv_at[k]) begin
        e.busy = 1'b1;
        if (n == rv_at[k]) begin
          e.rvalid0 = !win[k];
          e.rvalid1 = win[k];
          e.rdata   = b1.m_rdata;
        end
      end else if (b1.req0 || b1.req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        win[k] = !b1.req0;
`else
        win[k] = (b1.req0 && b1.req1) ? !last[k] : b1.req1;
`endif
        issue_at[k] = n + 1;
      end
      n_tot++;
      if (a[k] === e) n_pass++;
      else $display("FAIL model lat%0d cyc %0d: got %h want %h",
                    lat[k], n, a[k], e);
    end
    n++;
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      issue_at[k] = -1;
      rv_at[k]    = -1;
      last[k]     = 1'b1;
    end
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [1:0] rr_exp[4];
  logic [1:0] tie_exp;

  initial begin
`ifdef DM_ARB_FIXED_PRIO_EN
    rr_exp  = '{2'b01, 2'b01, 2'b01, 2'b01};
    tie_exp = 2'b01;
`else
    rr_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
    tie_exp = 2'b10;
`endif
    reset     = 1'b1;
    b1.req0   = 1'b0;
    b1.req1   = 1'b0;
    b1.addr0  = 32'd0;
    b1.addr1  = 32'd0;
    b1.wdata0 = 32'd0;
    b1.wdata1 = 32'd0;
    b1.be0    = 4'd0;
    b1.be1    = 4'd0;
    b1.m_rdata = 32'd0;
    #1 reset = 1'b0;
    repeat (2) nxt();
    smp();
    chk("rst_busy", b1.busy, 0);
    chk("rst_outs", {b3.gnt0, b3.gnt1, b3.m_en}, 0);

    // single read on port 0
    nxt();
    reset = 1'b1;
    b1.req0 = 1'b1;
    b1.be0 = 4'h0;
    b1.addr0 = 32'h10;
    b1.m_rdata = 32'hDEADBEEF;
    smp();
    chk("c0_gnt0", b1.gnt0, 0);
    nxt(); smp();
    chk("c1_gnt0", b1.gnt0, 1);
    chk("c1_m_en", b1.m_en, 1);
    chk("c1_m_addr", b1.m_addr, 32'h10);
    chk("c1_m_byteen", b1.m_byteen, 0);
    nxt();
    b1.req0 = 1'b0;
    smp();
    chk("c2_rvalid0", b1.rvalid0, 1);
    chk("c2_rdata", b1.rdata, 32'hDEADBEEF);
    chk("c2_l3_rvalid0", b3.rvalid0, 0);
    nxt(); smp();
    chk("c3_l3_rvalid0", b3.rvalid0, 0);
    nxt(); smp();
    chk("c4_l3_rvalid0", b3.rvalid0, 1);
    chk("c4_l3_rdata", b3.rdata, 32'hDEADBEEF);
    repeat (3) nxt();

    // tie of two writers from a fresh reset
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    b1.req0 = 1'b1; b1.be0 = 4'hF;
    b1.addr0 = 32'h100; b1.wdata0 = 32'h11111111;
    b1.req1 = 1'b1; b1.be1 = 4'hF;
    b1.addr1 = 32'h200; b1.wdata1 = 32'h22222222;
    for (int j = 0; j < 8; j++) begin
      smp();
      if (j % 2 == 1)
        chk("rr_seq", {b1.gnt1, b1.gnt0}, rr_exp[j / 2]);
      nxt();
    end
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
    repeat (3) nxt();

    // misaligned byte write, then aligned
    b1.req1 = 1'b1; b1.be1 = 4'b0010;
    b1.addr1 = 32'h2; b1.wdata1 = 32'h0000AB00;
    smp(); nxt(); smp();
    chk("bad_gnt1", b1.gnt1, 1);
    chk("bad_err1", b1.err1, 1);
    chk("bad_m_en", b1.m_en, 0);
    chk("bad_byteen", b1.m_byteen, 0);
    nxt();
    b1.addr1 = 32'h1;
    smp(); nxt(); smp();
    chk("ok_gnt1", b1.gnt1, 1);
    chk("ok_err1", b1.err1, 0);
    chk("ok_m_en", b1.m_en, 1);
    chk("ok_byteen", b1.m_byteen, 4'b0010);
    nxt();
    b1.req1 = 1'b0;
    repeat (3) nxt();

    // port 1 read, port 0 arrives mid-WAIT
    b1.req1 = 1'b1; b1.be1 = 4'h0; b1.addr1 = 32'h40;
    b1.m_rdata = 32'hCAFEF00D;
    smp(); nxt(); smp();
    chk("l3_gnt1", b3.gnt1, 1);
    nxt();
    b1.req1 = 1'b0;
    b1.req0 = 1'b1; b1.be0 = 4'h0; b1.addr0 = 32'h80;
    smp();
    chk("l3_w1_gnt0", b3.gnt0, 0);
    nxt(); smp();
    chk("l3_w2_rvalid1", b3.rvalid1, 0);
    nxt(); smp();
    chk("l3_w3_rvalid1", b3.rvalid1, 1);
    chk("l3_w3_rdata", b3.rdata, 32'hCAFEF00D);
    chk("l3_w3_gnt0", b3.gnt0, 0);
    nxt(); smp();
    chk("l3_idle_gnt0", b3.gnt0, 0);
    chk("l3_idle_busy", b3.busy, 0);
    nxt(); smp();
    chk("l3_next_gnt0", b3.gnt0, 1);
    nxt();
    b1.req0 = 1'b0;
    repeat (5) nxt();

    // reset while the slow instance waits
    b1.req0 = 1'b1; b1.be0 = 4'h0; b1.addr0 = 32'h30;
    b1.m_rdata = 32'h12345678;
    smp(); nxt(); smp();
    chk("rw_gnt0", b3.gnt0, 1);
    nxt();
    b1.req0 = 1'b0;
    smp();
    chk("rw_busy", b3.busy, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rw_async_busy", b3.busy, 0);
    chk("rw_async_rvalid", b3.rvalid0, 0);
    chk("rw_async_rdata", b3.rdata, 0);
    smp(); nxt();
    reset = 1'b1;
    b1.req0 = 1'b1; b1.be0 = 4'h0; b1.addr0 = 32'h34;
    smp();
    chk("rw_dropped", b3.rvalid0, 0);
    nxt(); smp();
    chk("rw_regnt_l3", b3.gnt0, 1);
    chk("rw_regnt_l1", b1.gnt0, 1);
    nxt();
    b1.req0 = 1'b0;
    repeat (5) nxt();

    // port 1 drops req in its ISSUE cycle
    b1.req1 = 1'b1; b1.be1 = 4'hF;
    b1.addr1 = 32'h0; b1.wdata1 = 32'h5A5A5A5A;
    smp(); nxt();
    b1.req1 = 1'b0;
    smp();
    chk("ab_gnt1", b1.gnt1, 0);
    chk("ab_m_en", b1.m_en, 0);
    chk("ab_busy", b1.busy, 1);
    nxt(); smp();
    chk("ab_idle", b1.busy, 0);
    nxt();
    b1.req0 = 1'b1; b1.be0 = 4'hF; b1.addr0 = 32'h0;
    b1.req1 = 1'b1; b1.be1 = 4'hF; b1.addr1 = 32'h4;
    smp(); nxt(); smp();
    chk("ab_tie", {b1.gnt1, b1.gnt0}, tie_exp);
    nxt();
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
    repeat (3) nxt();

    // unsupported byte-enable pattern
    b1.req0 = 1'b1; b1.be0 = 4'b0101; b1.addr0 = 32'h0;
    smp(); nxt(); smp();
    chk("be5_gnt0", b1.gnt0, 1);
    chk("be5_err0", b1.err0, 1);
    chk("be5_m_en", b1.m_en, 0);
    nxt();
    b1.req0 = 1'b0;
    repeat (4) nxt();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning the data-memory read latency in cycles (legal 1..3).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  request from CPU data port (0) and DMA (1).
REQ-005 SHALL have ports addr0/addr1  input  32, wdata0/wdata1  input  32, be0/be1  input  4  (be==0 means read; be!=0 means write, lane-aligned data).
REQ-006 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse.
REQ-007 SHALL have ports rvalid0/rvalid1  output  1  and rdata  output  32  (shared read-return bus).
REQ-008 SHALL have ports err0/err1  output  1  one-cycle illegal-byte-enable pulse.
REQ-009 SHALL have ports m_en  output  1, m_addr  output  32, m_wdata  output  32, m_byteen  output  4  to memory, m_rdata  input  32  from memory, busy  output  1.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT.
REQ-011 IDLE: if any req, latch winner and go to ISSUE next cycle; else stay.
REQ-012 Arbitration SHALL be round-robin: on both reqs, the requester not granted last wins; last-grant register resets to "1" so port 0 wins the first tie.
REQ-013 ISSUE: if winner's req is low, abort to IDLE with no gnt, no m_en, last-grant unchanged.
REQ-014 ISSUE with legal be: gnt<w>=1, m_en=1, m_addr/m_wdata/m_byteen driven from winner in the same cycle; write -> IDLE; read -> WAIT.
REQ-015 Legal be set: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; 0011/1100 additionally require addr[1]==be[2], 1111 requires addr[1:0]==00, single-byte patterns require addr[1:0] matching the lane.
REQ-016 ISSUE with illegal be/addr pair: gnt<w>=1, err<w>=1, m_en=0, last-grant updated, go to IDLE.
REQ-017 WAIT: counter counts MEM_LAT cycles from the ISSUE cycle; in the final cycle rvalid<w>=1 and rdata=m_rdata, then IDLE.
REQ-018 At most one transaction outstanding; no gnt while in ISSUE-to-WAIT sequence other than the issuing one.
REQ-019 busy=1 in ISSUE and WAIT, 0 in IDLE.
REQ-020 Read latency from req (IDLE) to rvalid SHALL be 1+MEM_LAT cycles; write occupies 2 cycles (IDLE, ISSUE).
REQ-021 When m_en=0, m_byteen SHALL be 0000; rdata SHALL be 0 when no rvalid.
REQ-022 Requests arriving in ISSUE/WAIT SHALL be held off until the next IDLE evaluation; the requester keeps req and operands stable until gnt.

Reset
REQ-023 Reset assertion SHALL force IDLE immediately, clear counter, set last-grant to 1, and drive all outputs to 0, including mid-WAIT (the pending rvalid is dropped).
REQ-024 First arbitration SHALL occur on the first rising edge after reset deassertion.

Configuration
REQ-025 With DM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win ties and last-grant is unused; without it, round-robin per REQ-012.

Structure
REQ-026 Shared package dm_arb_pkg SHALL hold the state enumeration, the legal byte-enable constants and the MEM_LAT bounds.
REQ-027 Winner selection SHALL be a sub-module dm_arb_rr (two inputs, last-grant input, one-hot winner output).

Verification
REQ-028 Reset release, req0=1 be0=0000 addr0=0x10, MEM_LAT=1, m_rdata=0xDEADBEEF -> gnt0 at cycle 1, m_en=1 m_addr=0x10 m_byteen=0000, rvalid0=1 rdata=0xDEADBEEF at cycle 2.
REQ-029 req0 and req1 both held as writes be=1111 -> grants alternate 0,1,0,1 every 2 cycles; with DM_ARB_FIXED_PRIO_EN defined -> gnt0 only.
REQ-030 req1 write be1=0010 addr1=0x2 -> gnt1=1, err1=1, m_en=0; be1=0010 addr1=0x1 -> m_byteen=0010, m_en=1, err1=0.
REQ-031 MEM_LAT=3 read on port 1 with req0 raised during WAIT -> rvalid1 exactly 3 cycles after gnt1, gnt0 not before the following IDLE cycle + 1.
REQ-032 Reset asserted during WAIT -> all outputs 0 asynchronously, no rvalid after release, next req0 granted normally.
REQ-033 req1 dropped in the ISSUE cycle -> no gnt1, m_en=0, return to IDLE, last-grant unchanged.
